// File: rtl/float_fixed_conv.sv
// IEEE-754 single to signed Q(M).(N) fixed-point converter.
// Multi-cycle FSM with valid/ready handshakes on both the input and the output side.
module float_fixed_conv #(
  parameter int M = 16,
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      float_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M+N-1:0]   fixed_out,
  output logic             overflow,
  output logic             invalid
);
  // state  | meaning
  // IDLE   | waiting for a float, in_ready=1
  // DECODE | split sign/exponent/mantissa, classify, compute shift k
  // SHIFT  | align mantissa into magnitude, flag overflow from the shift
  // PACK   | apply sign, saturate, load result registers
  // HOLD   | present result until out_ready
  localparam int W = M + N;
  localparam logic signed [11:0] K_OFF = 12'(N - 150);
  localparam logic signed [11:0] K_MAX = 12'(W - 24);
  localparam logic [W:0] POS_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0] NEG_MAX = {2'b01, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, DECODE, SHIFT, PACK, HOLD} state_t;
  state_t state, state_n;

  logic [31:0]        f_q;
  logic               sign_q, nan_q, inf_q, zero_q, sh_ovf_q;
  logic [23:0]        mant_q;
  logic signed [11:0] k_q, k_neg;
  logic [W:0]         mag_q, mag_n, ext_m, mag_neg;
  logic               sh_ovf_n;
  logic [W-1:0]       pack_val;
  logic               pack_ovf, pack_inv;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = DECODE;
      DECODE:  state_n = SHIFT;
      SHIFT:   state_n = PACK;
      PACK:    state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Alignment: left shifts beyond K_MAX push the leading one to bit W or above.
  always_comb begin
    ext_m    = {{(W+1-24){1'b0}}, mant_q};
    k_neg    = -k_q;
    mag_n    = '0;
    sh_ovf_n = 1'b0;
    if (!k_q[11]) begin
      if (k_q > K_MAX) sh_ovf_n = 1'b1;
      else             mag_n    = ext_m << k_q;
    end else if (k_neg < 12'sd24) begin
      mag_n = ext_m >> k_neg;
    end
  end

  // Negative side allows magnitude 2^(W-1) so the most negative value is exact.
  always_comb begin
    mag_neg  = -mag_q;
    pack_val = '0;
    pack_ovf = 1'b0;
    pack_inv = 1'b0;
    if (nan_q) begin
      pack_inv = 1'b1;
    end else if (inf_q || sh_ovf_q ||
                 (!sign_q && mag_q > POS_MAX) || (sign_q && mag_q > NEG_MAX)) begin
      pack_ovf = !zero_q;
      if (!zero_q) pack_val = sign_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else if (!zero_q) begin
      pack_val = sign_q ? mag_neg[W-1:0] : mag_q[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q       <= '0;
      sign_q    <= 1'b0;
      nan_q     <= 1'b0;
      inf_q     <= 1'b0;
      zero_q    <= 1'b0;
      sh_ovf_q  <= 1'b0;
      mant_q    <= '0;
      k_q       <= '0;
      mag_q     <= '0;
      fixed_out <= '0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          f_q       <= float_in;
          fixed_out <= '0;
          overflow  <= 1'b0;
          invalid   <= 1'b0;
        end
        DECODE: begin
          sign_q <= f_q[31];
          mant_q <= {|f_q[30:23], f_q[22:0]};
          k_q    <= $signed({4'b0000, f_q[30:23]}) + K_OFF;
          nan_q  <= (&f_q[30:23]) && (|f_q[22:0]);
          inf_q  <= (&f_q[30:23]) && !(|f_q[22:0]);
          zero_q <= (f_q[30:23] == 8'h00);
        end
        SHIFT: begin
          mag_q    <= mag_n;
          sh_ovf_q <= sh_ovf_n;
        end
        PACK: begin
          fixed_out <= pack_val;
          overflow  <= pack_ovf;
          invalid   <= pack_inv;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_float_fixed_conv.sv
// Bench for float_fixed_conv (M=16, N=16): directed table, random vectors against an
// arithmetic model, and handshake/reset sequences.
module tb_float_fixed_conv;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] float_in = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] fixed_out;
  logic        overflow;
  logic        invalid;

  int checks = 0;
  int errors = 0;

  float_fixed_conv dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .float_in(float_in), .out_valid(out_valid), .out_ready(out_ready),
    .fixed_out(fixed_out), .overflow(overflow), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    logic [31:0] q;
    logic        ov;
    logic        inv;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Value*2^16 = m * 2^(e-150+16); saturate on the signed 32-bit range.
  function automatic vec_t model(input logic [31:0] f);
    vec_t r;
    int e, sh;
    longint m, mag;
    r.f = f; r.q = 0; r.ov = 0; r.inv = 0;
    e = int'(f[30:23]);
    m = longint'({1'b1, f[22:0]});
    if (e == 255) begin
      if (f[22:0] != 0) r.inv = 1;
      else begin r.ov = 1; r.q = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; end
      return r;
    end
    if (e == 0) return r;
    sh = e - 134;
    if (sh >= 20)      mag = 64'sd1 <<< 40;
    else if (sh >= 0)  mag = m <<< sh;
    else if (sh > -40) mag = m >>> (-sh);
    else               mag = 0;
    if (f[31]) begin
      if (mag > 64'sd2147483648) begin r.ov = 1; r.q = 32'h8000_0000; end
      else r.q = 32'(-mag);
    end else begin
      if (mag > 64'sd2147483647) begin r.ov = 1; r.q = 32'h7FFF_FFFF; end
      else r.q = 32'(mag);
    end
    return r;
  endfunction

  // Accept f, check latency and result, hold for hold_cyc cycles, then release.
  task automatic run_one(input logic [31:0] f, input vec_t exp, input int hold_cyc);
    int lat, w;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
      return;
    end
    in_valid = 1; float_in = f;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency_edges", 32'(lat), 32'd4);
    chk($sformatf("fixed_%h", f), fixed_out, exp.q);
    chk($sformatf("ovf_%h", f), {31'b0, overflow}, {31'b0, exp.ov});
    chk($sformatf("inv_%h", f), {31'b0, invalid}, {31'b0, exp.inv});
    for (int i = 0; i < hold_cyc; i++) begin
      in_valid = i[0]; float_in = 32'h3F80_0000;
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_fixed", fixed_out, exp.q);
      chk("hold_flags", {30'b0, overflow, invalid}, {30'b0, exp.ov, exp.inv});
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("release_valid", {31'b0, out_valid}, 32'd0);
  endtask

  vec_t tbl[10];
  vec_t e;
  logic [31:0] f;

  initial begin
    tbl[0] = '{32'h3FC0_0000, 32'h0001_8000, 1'b0, 1'b0};
    tbl[1] = '{32'hC020_0000, 32'hFFFD_8000, 1'b0, 1'b0};
    tbl[2] = '{32'h4700_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    tbl[3] = '{32'hC700_0000, 32'h8000_0000, 1'b0, 1'b0};
    tbl[4] = '{32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1};
    tbl[5] = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
    tbl[7] = '{32'h3780_0000, 32'h0000_0001, 1'b0, 1'b0};
    tbl[8] = '{32'h3380_0000, 32'h0000_0000, 1'b0, 1'b0};
    tbl[9] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};

    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_fixed", fixed_out, 32'd0);
    chk("rst_flags", {30'b0, overflow, invalid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_one(tbl[i].f, tbl[i], 0);

    // Output held off for 10 cycles with in_valid pulses.
    run_one(32'hC020_0000, model(32'hC020_0000), 10);

    // in_valid and out_ready together in HOLD: only the output is taken.
    in_valid = 1; float_in = 32'h4000_0000;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("hold_reached", {31'b0, out_valid}, 32'd1);
    chk("hold_value", fixed_out, 32'h0002_0000);
    in_valid = 1; out_ready = 1; float_in = 32'h3F80_0000;
    @(posedge clk); #1;
    out_ready = 0;
    chk("overlap_no_accept", {31'b0, in_ready}, 32'd1);
    chk("overlap_out_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 0;

    // Reset during SHIFT discards the transaction.
    in_valid = 1; float_in = 32'h3FC0_0000;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_fixed", fixed_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
    chk("midrst_no_output", {31'b0, out_valid}, 32'd0);

    // Random floats, exponents biased around the representable range.
    for (int i = 0; i < 300; i++) begin
      f = $urandom;
      if (i % 3 != 0) f[30:23] = 8'(100 + $urandom_range(0, 50));
      e = model(f);
      run_one(f, e, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
